// File: rtl/fb_uart_dump_if.sv
// fb_uart_dump_if: read-request and read-data bundle between the frame-buffer
// UART dump engine and the sdrc_core application read port.
//
// Signals:
//   mem_req      requester -> controller  read request (app_req)
//   mem_addr     requester -> controller  word address (app_req_addr)
//   mem_len      requester -> controller  words per request (constant burst size)
//   mem_ack      controller -> requester  request accepted (app_req_ack)
//   mem_rd_valid controller -> requester  one pulse per returned word
//   mem_rd_data  controller -> requester  returned word
//
// Handshake: mem_req rises and then holds together with mem_addr and mem_len
// until mem_ack is sampled high on a rising clk edge. That edge completes the
// request and mem_req drops on the next cycle. After the ack the controller
// returns exactly mem_len words, one per cycle in which mem_rd_valid is high.
// mem_rd_valid has no ready; the requester must accept every word.

interface fb_uart_dump_if #(
    parameter int AW = 25
);
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic [8:0]    mem_len;
    logic          mem_ack;
    logic          mem_rd_valid;
    logic [31:0]   mem_rd_data;

    modport master (
        output mem_req,
        output mem_addr,
        output mem_len,
        input  mem_ack,
        input  mem_rd_valid,
        input  mem_rd_data
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        input  mem_len,
        output mem_ack,
        output mem_rd_valid,
        output mem_rd_data
    );
endinterface

// File: rtl/fb_uart_dump.sv
// fb_uart_dump: reads a region of the SDRAM frame buffer in BURST-word read
// requests and streams every byte out of tx as 8N1 UART. Words are sent in
// address order. Within each word, bits [7:0] are sent first.
//
// Ports:
//   clk         mem_clk domain clock
//   reset_n     asynchronous active-low reset
//   start       one-cycle pulse that begins a dump; ignored while busy
//   start_addr  first word address; the low log2(BURST) bits are forced to 0
//   num_bursts  number of bursts to dump; 0 finishes at once with no transfer
//   busy        high from the cycle after an accepted start until done
//   done        one-cycle pulse when the dump ends
//   mem         fb_uart_dump_if.master read port toward sdrc_core
//   tx          UART line, idle high
//   dbg_state   current FSM state
//
// Optional feature: define FB_DUMP_CSUM_EN to append one byte after the last
// burst. That byte is the modulo-256 sum of all data bytes in the dump.

module fb_uart_dump #(
    parameter int CLKS_PER_BIT = 868,
    parameter int AW           = 25,
    parameter int BURST        = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [AW-1:0]      start_addr,
    input  logic [15:0]        num_bursts,
    output logic               busy,
    output logic               done,
    fb_uart_dump_if.master     mem,
    output logic               tx,
    output logic [2:0]         dbg_state
);

    localparam int WPW = $clog2(BURST) + 1;  // fill pointer must reach BURST
    localparam int BCW = $clog2(4 * BURST);  // byte index within one burst
    localparam logic [AW-1:0] ADDR_MASK = ~AW'(BURST - 1);

    typedef enum logic [2:0] {
        IDLE, REQ, FILL, SEND, NEXT, FIN
`ifdef FB_DUMP_CSUM_EN
        , CSUM
`endif
    } state_t;

    state_t               state_q, state_d;
    logic [AW-1:0]        addr_q;
    logic [15:0]          remaining_q;
    logic [32*BURST-1:0]  buf_q;
    logic [WPW-1:0]       wptr_q;
    logic [BCW-1:0]       byte_cnt_q;
    logic [3:0]           bit_cnt_q;
    logic [15:0]          clk_cnt_q;

    logic                 sending;
    logic                 bit_end;
    logic                 byte_end;
    logic                 last_word;
    logic                 last_byte;
    logic                 start_ok;
    logic [7:0]           cur_byte;
    logic [7:0]           tx_byte;
    logic [9:0]           frame_sh;

`ifdef FB_DUMP_CSUM_EN
    logic [7:0]           csum_q;
    assign sending = (state_q == SEND) || (state_q == CSUM);
    assign tx_byte = (state_q == CSUM) ? csum_q : cur_byte;
`else
    assign sending = (state_q == SEND);
    assign tx_byte = cur_byte;
`endif

    assign start_ok  = (state_q == IDLE) && start && (num_bursts != 16'd0);
    assign bit_end   = (clk_cnt_q == 16'(CLKS_PER_BIT - 1));
    assign byte_end  = bit_end && (bit_cnt_q == 4'd9);
    assign last_word = mem.mem_rd_valid && (wptr_q == WPW'(BURST - 1));
    assign last_byte = (byte_cnt_q == BCW'(4 * BURST - 1));

    // Byte byte_cnt_q of the burst buffer. Word 0 sits in the low 32 bits,
    // so the byte index maps directly onto 8-bit lanes.
    always_comb begin
        cur_byte = 8'h00;
        for (int i = 0; i < 4 * BURST; i++) begin
            if (byte_cnt_q == BCW'(i)) begin
                cur_byte = buf_q[i*8 +: 8];
            end
        end
    end

    // The 8N1 frame is sent LSB first. Shifting the frame by the bit index
    // selects start, data or stop without variable bit-select widths.
    assign frame_sh = {1'b1, tx_byte, 1'b0} >> bit_cnt_q;
    assign tx       = sending ? frame_sh[0] : 1'b1;

    assign busy         = (state_q != IDLE) && (state_q != FIN);
    assign done         = (state_q == FIN);
    assign mem.mem_req  = (state_q == REQ);
    assign mem.mem_addr = addr_q;
    assign mem.mem_len  = 9'(BURST);
    assign dbg_state    = state_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = (num_bursts != 16'd0) ? REQ : FIN;
            REQ:  if (mem.mem_ack) state_d = FILL;
            FILL: if (last_word) state_d = SEND;
            SEND: if (byte_end && last_byte) state_d = NEXT;
            NEXT: begin
                if (remaining_q != 16'd1) begin
                    state_d = REQ;
                end else begin
`ifdef FB_DUMP_CSUM_EN
                    state_d = CSUM;
`else
                    state_d = FIN;
`endif
                end
            end
`ifdef FB_DUMP_CSUM_EN
            CSUM: if (byte_end) state_d = FIN;
`endif
            FIN:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q      <= '0;
            remaining_q <= '0;
            buf_q       <= '0;
            wptr_q      <= '0;
            byte_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            clk_cnt_q   <= '0;
        end else begin
            if (start_ok) begin
                addr_q      <= start_addr & ADDR_MASK;
                remaining_q <= num_bursts;
            end else if (state_q == NEXT) begin
                addr_q      <= addr_q + AW'(BURST);
                remaining_q <= remaining_q - 16'd1;
            end

            // Returned words are captured only while filling. Stray valids are dropped.
            if (state_q == FILL) begin
                if (mem.mem_rd_valid) begin
                    for (int i = 0; i < BURST; i++) begin
                        if (wptr_q == WPW'(i)) begin
                            buf_q[i*32 +: 32] <= mem.mem_rd_data;
                        end
                    end
                    wptr_q <= wptr_q + WPW'(1);
                end
            end else begin
                wptr_q <= '0;
            end

            // Bit and byte timing. The byte counter wraps back to 0 after the
            // last byte because 4*BURST is a power of two.
            if (sending) begin
                if (bit_end) begin
                    clk_cnt_q <= '0;
                    if (bit_cnt_q == 4'd9) begin
                        bit_cnt_q  <= '0;
                        byte_cnt_q <= byte_cnt_q + BCW'(1);
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                    end
                end else begin
                    clk_cnt_q <= clk_cnt_q + 16'd1;
                end
            end else begin
                clk_cnt_q  <= '0;
                bit_cnt_q  <= '0;
                byte_cnt_q <= '0;
            end
        end
    end

`ifdef FB_DUMP_CSUM_EN
    // Each data byte is added once, in the first cycle of its start bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            csum_q <= '0;
        end else if (start_ok) begin
            csum_q <= '0;
        end else if ((state_q == SEND) && (bit_cnt_q == 4'd0) && (clk_cnt_q == 16'd0)) begin
            csum_q <= csum_q + cur_byte;
        end
    end
`endif

endmodule

// File: tb/tb_fb_uart_dump.sv
module tb_fb_uart_dump;

    localparam int CPB   = 4;
    localparam int AW    = 25;
    localparam int BURST = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic          start = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [15:0]   num_bursts = '0;
    logic          busy, done, tx;
    logic [2:0]    dbg_state;

    fb_uart_dump_if #(.AW(AW)) mem_if ();

    fb_uart_dump #(.CLKS_PER_BIT(CPB), .AW(AW), .BURST(BURST)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .start_addr (start_addr),
        .num_bursts (num_bursts),
        .busy       (busy),
        .done       (done),
        .mem        (mem_if.master),
        .tx         (tx),
        .dbg_state  (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [8:0]    exp_q[$];       // {last_of_group, byte}
    logic [AW-1:0] exp_addr_q[$];
    logic [AW-1:0] req_log[$];
    int   req_cnt = 0;
    int   rx_bytes = 0;
    logic [7:0] last_rx = '0;
    int   first_fall = -1;
    int   start_cyc = 0;
    bit   mon_en = 1'b1;
    int   ack_delay = 0;
    bit   stray = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, req);
        end
    endtask

    task automatic fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: bound expired or unexpected event", name);
    endtask

    // Memory contents: word A holds bytes 4A, 4A+1, 4A+2, 4A+3 (mod 256), low byte first.
    function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
        logic [7:0] b;
        b = {a[5:0], 2'b00};
        return {b + 8'd3, b + 8'd2, b + 8'd1, b};
    endfunction

    // Model: the expected request addresses and byte stream of one dump.
    task automatic push_dump(input logic [AW-1:0] a, input int nb);
        logic [AW-1:0] ad;
        logic [31:0]   w;
        logic [7:0]    sum;
        ad  = a & ~AW'(BURST - 1);
        sum = 8'h00;
        for (int b = 0; b < nb; b++) begin
            exp_addr_q.push_back(ad);
            for (int i = 0; i < BURST; i++) begin
                w = mem_word(ad + AW'(i));
                for (int k = 0; k < 4; k++) begin
                    sum = sum + w[8*k +: 8];
                    exp_q.push_back({(i == BURST - 1) && (k == 3), w[8*k +: 8]});
                end
            end
            ad = ad + AW'(BURST);
        end
`ifdef FB_DUMP_CSUM_EN
        if (nb != 0) exp_q.push_back({1'b1, sum});
`endif
    endtask

    // ---------------- memory responder ----------------
    initial begin
        logic [AW-1:0] cap;
        mem_if.mem_ack      = 1'b0;
        mem_if.mem_rd_valid = 1'b0;
        mem_if.mem_rd_data  = '0;
        forever begin
            @(negedge clk);
            if (reset_n && mem_if.mem_req) begin
                cap = mem_if.mem_addr;
                req_cnt++;
                req_log.push_back(cap);
                check("req_len", 32'(mem_if.mem_len), 32'd8);
                if (exp_addr_q.size() == 0) fail("unexpected_req");
                else check("req_addr", 32'(cap), 32'(exp_addr_q.pop_front()));
                for (int d = 0; d < ack_delay; d++) begin
                    mem_if.mem_rd_valid = stray && (d % 3 == 0);
                    mem_if.mem_rd_data  = 32'hDEADBEEF;
                    @(negedge clk);
                    check("req_hold", {6'b0, mem_if.mem_req, mem_if.mem_addr}, {6'b0, 1'b1, cap});
                end
                mem_if.mem_rd_valid = 1'b0;
                mem_if.mem_ack      = 1'b1;
                @(negedge clk);
                mem_if.mem_ack = 1'b0;
                check("req_drop", 32'(mem_if.mem_req), 32'd0);
                for (int i = 0; i < BURST; i++) begin
                    mem_if.mem_rd_valid = 1'b1;
                    mem_if.mem_rd_data  = mem_word(cap + AW'(i));
                    @(negedge clk);
                end
                mem_if.mem_rd_valid = 1'b0;
            end
        end
    end

    // ---------------- tx compare process ----------------
    initial begin
        logic [8:0] item;
        logic [7:0] rx_val;
        bit have, aborted, ok, exp_start, eb;
        int bi;
        exp_start = 1'b0;
        forever begin
            @(negedge clk);
            if (!mon_en || !reset_n) begin
                exp_start = 1'b0;
                continue;
            end
            if (exp_start) begin
                check("no_gap", 32'(tx), 32'd0);
                exp_start = 1'b0;
            end
            if (tx === 1'b0) begin
                have = (exp_q.size() != 0);
                item = have ? exp_q.pop_front() : 9'h000;
                if (!have) fail("unexpected_byte");
                if (first_fall < 0) first_fall = cyc;
                aborted = 1'b0;
                ok      = 1'b1;
                rx_val  = 8'h00;
                for (int c = 1; c < 10 * CPB; c++) begin
                    @(negedge clk);
                    if (!mon_en || !reset_n) begin
                        aborted = 1'b1;
                        break;
                    end
                    bi = c / CPB;
                    eb = (bi == 0) ? 1'b0 : (bi == 9) ? 1'b1 : item[bi-1];
                    if (tx !== eb) ok = 1'b0;
                    if (bi >= 1 && bi <= 8 && (c % CPB) == CPB / 2) rx_val[bi-1] = tx;
                end
                if (!aborted && have) begin
                    n_tests++;
                    if (!ok) begin
                        n_fail++;
                        $display("FAIL tx_byte: actual %h required %h", rx_val, item[7:0]);
                    end
                    rx_bytes++;
                    last_rx   = rx_val;
                    exp_start = !item[8];
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_start(input logic [AW-1:0] a, input int nb);
        @(negedge clk);
        start_addr = a;
        num_bursts = 16'(nb);
        start      = 1'b1;
        start_cyc  = cyc;
        first_fall = -1;
        @(negedge clk);
        start = 1'b0;
        if (nb != 0) begin
            check("busy_after_start", 32'(busy), 32'd1);
        end else begin
            check("zero_done", 32'(done), 32'd1);
            check("zero_busy", 32'(busy), 32'd0);
        end
    endtask

    task automatic wait_done(input int budget, input bit fin_start);
        int n;
        bit busy_ok;
        n = 0;
        busy_ok = 1'b1;
        while (!done && n < budget) begin
            if (!busy) busy_ok = 1'b0;
            @(negedge clk);
            n++;
        end
        if (!done) begin
            fail("done_timeout");
        end else begin
            check("busy_held", 32'(busy_ok), 32'd1);
            check("busy_at_done", 32'(busy), 32'd0);
            if (fin_start) begin
                start_addr = 25'h400;
                num_bursts = 16'd2;
                start      = 1'b1;
            end
            @(negedge clk);
            start = 1'b0;
            check("done_pulse", 32'(done), 32'd0);
            check("idle_after_done", 32'(busy), 32'd0);
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int r0, x0, n;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_req", 32'(mem_if.mem_req), 32'd0);
        check("rst_addr", 32'(mem_if.mem_addr), 32'd0);
        check("rst_tx", 32'(tx), 32'd1);
        reset_n = 1'b1;

        check("model_w0", mem_word(25'h100), 32'h03020100);
        check("model_w7", mem_word(25'h107), 32'h1F1E1D1C);

        // single burst at 0x100
        r0 = req_cnt; x0 = rx_bytes;
        push_dump(25'h100, 1);
        do_start(25'h100, 1);
        wait_done(3000, 1'b0);
        check("t1_latency", 32'(first_fall - start_cyc), 32'd10);
        check("t1_reqs", 32'(req_cnt - r0), 32'd1);
        check("t1_req_addr", 32'(req_log[r0]), 32'h100);
        check("t1_left", 32'(exp_q.size()), 32'd0);
`ifdef FB_DUMP_CSUM_EN
        check("t1_count", 32'(rx_bytes - x0), 32'd33);
        check("t1_csum", 32'(last_rx), 32'hF0);
`else
        check("t1_count", 32'(rx_bytes - x0), 32'd32);
        check("t1_last", 32'(last_rx), 32'h1F);
`endif

        // three bursts, unaligned start, address wrap
        r0 = req_cnt; x0 = rx_bytes;
        push_dump(25'h1FFFFF3, 3);
        do_start(25'h1FFFFF3, 3);
        wait_done(8000, 1'b0);
        check("t2_reqs", 32'(req_cnt - r0), 32'd3);
        check("t2_addr0", 32'(req_log[r0]), 32'h1FFFFF0);
        check("t2_addr1", 32'(req_log[r0+1]), 32'h1FFFFF8);
        check("t2_addr2", 32'(req_log[r0+2]), 32'h0);
        check("t2_left", 32'(exp_q.size()), 32'd0);
`ifdef FB_DUMP_CSUM_EN
        check("t2_count", 32'(rx_bytes - x0), 32'd97);
`else
        check("t2_count", 32'(rx_bytes - x0), 32'd96);
`endif

        // delayed ack with stray valids, start while busy, start in FIN cycle
        ack_delay = 20; stray = 1'b1;
        r0 = req_cnt;
        push_dump(25'h100, 1);
        do_start(25'h100, 1);
        start_addr = 25'h400; num_bursts = 16'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(3000, 1'b1);
        repeat (4) @(negedge clk);
        check("t3_fin_start_busy", 32'(busy), 32'd0);
        check("t3_reqs", 32'(req_cnt - r0), 32'd1);
        check("t3_left", 32'(exp_q.size()), 32'd0);
        ack_delay = 0; stray = 1'b0;

        // zero bursts
        r0 = req_cnt;
        do_start(25'h300, 0);
        wait_done(10, 1'b0);
        repeat (3) @(negedge clk);
        check("t4_reqs", 32'(req_cnt - r0), 32'd0);
        check("t4_tx", 32'(tx), 32'd1);

        // reset mid-byte in burst 2
        x0 = rx_bytes;
        push_dump(25'h200, 3);
        do_start(25'h200, 3);
        n = 0;
        while (rx_bytes < x0 + 34 && n < 6000) begin
            @(negedge clk);
            n++;
        end
        if (rx_bytes < x0 + 34) fail("t5_wait_bytes");
        repeat (5) @(negedge clk);
        mon_en = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check("t5_tx", 32'(tx), 32'd1);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_req", 32'(mem_if.mem_req), 32'd0);
        @(negedge clk);
        exp_q.delete();
        exp_addr_q.delete();
        reset_n = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;

        // clean dump after reset
        r0 = req_cnt; x0 = rx_bytes;
        push_dump(25'h180, 1);
        do_start(25'h180, 1);
        wait_done(3000, 1'b0);
        check("t6_reqs", 32'(req_cnt - r0), 32'd1);
        check("t6_addr", 32'(req_log[r0]), 32'h180);
        check("t6_left", 32'(exp_q.size()), 32'd0);
`ifdef FB_DUMP_CSUM_EN
        check("t6_count", 32'(rx_bytes - x0), 32'd33);
`else
        check("t6_count", 32'(rx_bytes - x0), 32'd32);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fb_uart_dump.md
Name: fb_uart_dump

Overview:
Reads a region of the SDRAM frame buffer through the sdrc_core application read port in 8-word bursts. It streams the data out on serial_tx as 8N1 UART bytes. It is the readback counterpart of the serial-to-SDRAM write path, and it shares the sdrc_core request port with the video reader through the top-level arbitration mux. One clock domain: mem_clk.

Parameters:
CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); legal range 2..65535
AW, 25, SDRAM application address width
BURST, 8, words per read request; power of two, 1..16

Ports:
clk  in  1  mem_clk domain clock
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; starts a dump; ignored while busy=1
start_addr  in  AW  first word address, sampled on start; low log2(BURST) bits forced to 0
num_bursts  in  16  bursts to dump, sampled on start; 0 means no transfer
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse at end of dump
mem_req  out  1  read request to sdrc_core (app_req)
mem_addr  out  AW  request address (app_req_addr)
mem_len  out  9  burst length, constant BURST
mem_ack  in  1  app_req_ack
mem_rd_valid  in  1  app_rd_valid, one per returned word
mem_rd_data  in  32  app_rd_data
tx  out  1  UART line, idle high

Behaviour:
- Reset values: busy=0, done=0, mem_req=0, mem_addr=0, tx=1. All state is cleared asynchronously; a reset mid-frame truncates the byte and tx returns to 1 immediately.
- FSM states: IDLE, REQ, FILL, SEND, NEXT, FIN.
- IDLE -> REQ on start with num_bursts!=0. On the same edge: latch address, set remaining=num_bursts, busy=1.
- IDLE -> FIN on start with num_bursts==0.
- REQ: mem_req=1 and mem_addr are held stable until mem_ack is sampled high. On the ack cycle, mem_req drops to 0 and the FSM moves to FILL.
- FILL: each mem_rd_valid writes mem_rd_data to buf[wptr] and increments wptr. After BURST words -> SEND.
- mem_rd_valid in any state other than FILL is ignored.
- There is no timeout; the controller guarantees BURST words per ack.
- SEND: bytes go out word 0 first, and within each word bits[7:0] first, through bits[31:24].
- Each byte on tx: start bit 0, 8 data bits LSB first, stop bit 1. Every bit lasts exactly CLKS_PER_BIT cycles.
- The next byte's start bit follows the stop bit immediately; there is no idle gap inside a dump.
- SEND ends after the stop bit of byte 4*BURST-1 -> NEXT.
- NEXT: address += BURST, wrapping modulo 2^AW; remaining -= 1.
- NEXT -> REQ if remaining!=0, else -> FIN.
- FIN: done=1 for one cycle, busy=0 -> IDLE. Between bursts, tx idles high for the request and fill time.
- A start arriving while busy=1 is dropped and not queued.
- start and done may coincide only after FIN has returned to IDLE; a start in the FIN cycle is ignored.
- Latency from start to tx falling edge = 1 + ack wait + fill time + 1 cycle.
- Throughput bound: one burst per 4*BURST*10*CLKS_PER_BIT cycles, plus memory time.

Optional Feature:
Macro FB_DUMP_CSUM_EN.
- Defined: after the last byte of the last burst, FSM state CSUM transmits one extra byte before FIN. The byte is the 8-bit modulo-256 sum of every data byte in the dump. The sum clears on an accepted start.
- Not defined: no CSUM state, no accumulator; NEXT goes directly to FIN.

Test Plan:
- CLKS_PER_BIT=4, start_addr=0x100, num_bursts=1, memory model returns 0x03020100..0x1F1E1D1C -> one mem_req at 0x100 with mem_len=8, tx carries bytes 0x00..0x1F in order, each bit 4 cycles, then done pulse and busy=0.
- num_bursts=3, start_addr=0x1FFFFF0 -> requests at 0x1FFFFF0, 0x1FFFFF8, 0x0000000 (wrap), 96 bytes total, tx high between bursts.
- mem_ack delayed 20 cycles, with stray mem_rd_valid pulses during REQ -> mem_req and mem_addr stable for all 20 cycles, stray words not captured, output bytes unchanged.
- start with num_bursts=0 -> no mem_req, done one cycle later, tx stays 1; a second start while busy -> ignored, request count unchanged.
- reset_n low mid-byte during SEND of burst 2 -> tx=1, busy=0, mem_req=0 at once; a following start runs a clean dump.
- FB_DUMP_CSUM_EN defined, data bytes 0x00..0x1F -> extra final byte 0xF0 (sum 496 mod 256) before done; without the macro, exactly 32 bytes.
